// File: rtl/moving_average_pkg.sv
// Shared definitions for the moving-average controller and filter engine.
// Holds default widths, window size and the controller state encoding.
package moving_average_pkg;

    localparam int DATA_W       = 8;
    localparam int FILTER_POWER = 2;
    localparam int WINDOW       = 1 << FILTER_POWER;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BUSY    = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/moving_average_if.sv
// Source-side valid/ready sample handshake.
// The source drives data/valid; the controller answers with ready.
interface moving_average_if #(
    parameter int DATA_W = moving_average_pkg::DATA_W
);

    logic [DATA_W-1:0] src_data_i;
    logic              src_valid_i;
    logic              src_ready_o;

    modport master (
        output src_data_i,
        output src_valid_i,
        input  src_ready_o
    );

    modport slave (
        input  src_data_i,
        input  src_valid_i,
        output src_ready_o
    );

endinterface

// File: rtl/ma_tick_gen.sv
// Programmable sample-rate divider with a single pending-slot flag.
// A tick every div_i+1 enabled cycles; pend holds until the slot is used.
module ma_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] div_i,
    input  logic             clr_pend,
    output logic             tick,
    output logic             pend
);

    import moving_average_pkg::*;

    logic [DIV_W-1:0] cnt_q;

    assign tick = ena && (cnt_q == div_i);

    // Divider count; wraps on tick, or silently when div_i drops below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (cnt_q >= div_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Pending slot: a fresh tick outranks the accept that consumes a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (tick) begin
            pend <= 1'b1;
        end else if (clr_pend) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/moving_average_ctrl.sv
// Sequencing controller between the tile pins and the filter engine.
// Paces samples, strobes the engine, captures results, flags errors.
module moving_average_ctrl #(
    parameter int DATA_W       = moving_average_pkg::DATA_W,
    parameter int FILTER_POWER = moving_average_pkg::FILTER_POWER,
    parameter int DIV_W        = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    moving_average_if.slave   src,
    input  logic [DIV_W-1:0]  div_i,
    output logic [DATA_W-1:0] eng_data_o,
    output logic              eng_strobe_o,
    input  logic              eng_done_i,
    input  logic [DATA_W-1:0] eng_avg_i,
    output logic [DATA_W-1:0] avg_o,
    output logic              avg_valid_o,
    output logic              warm_o,
    input  logic              clr_err_i,
    output logic              err_overrun_o,
    output logic              err_timeout_o
);

    import moving_average_pkg::*;

    localparam int WIN  = 1 << FILTER_POWER;
    localparam int WC_W = FILTER_POWER + 1;
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_e            state_q;
    state_e            state_d;
    logic              tick;
    logic              pend;
    logic              accept;
    logic              timeout_hit;
    logic              ovr_evt;
    logic [WD_W-1:0]   wd_q;
    logic [WC_W-1:0]   warm_cnt_q;

    assign src.src_ready_o = ena && pend && (state_q == S_IDLE);
    assign accept          = src.src_valid_i && src.src_ready_o;
    assign timeout_hit     = (state_q == S_BUSY) && !eng_done_i
                             && (wd_q == WD_W'(TIMEOUT - 1));
    assign ovr_evt         = tick && (state_q != S_IDLE);

    ma_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .div_i    (div_i),
        .clr_pend (accept),
        .tick     (tick),
        .pend     (pend)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: done beats a coincident watchdog expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (eng_done_i) begin
                    state_d = S_CAPTURE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Watchdog counts BUSY cycles, restarting from zero on each entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q == S_BUSY) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    // Held sample and strobe; hold only changes on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_data_o   <= '0;
            eng_strobe_o <= 1'b0;
        end else begin
            eng_strobe_o <= accept;
            if (accept) eng_data_o <= src.src_data_i;
        end
    end

    // Result capture and warm-up tracking, saturating at one window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
            warm_cnt_q  <= '0;
            warm_o      <= 1'b0;
        end else begin
            avg_valid_o <= (state_q == S_CAPTURE);
            if (state_q == S_CAPTURE) begin
                avg_o <= eng_avg_i;
                if (warm_cnt_q != WC_W'(WIN)) begin
                    warm_cnt_q <= warm_cnt_q + 1'b1;
                end
                if (warm_cnt_q >= WC_W'(WIN - 1)) begin
                    warm_o <= 1'b1;
                end
            end
        end
    end

    // Sticky error flags; a new event outranks clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun_o <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            if (ovr_evt) begin
                err_overrun_o <= 1'b1;
            end else if (clr_err_i) begin
                err_overrun_o <= 1'b0;
            end
            if (timeout_hit) begin
                err_timeout_o <= 1'b1;
            end else if (clr_err_i) begin
                err_timeout_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Directed bench for moving_average_ctrl with a delay-programmable engine model.
// Inputs and checks happen on the falling edge.
module tb_moving_average_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] div_i;
    logic [7:0] eng_data_o;
    logic       eng_strobe_o;
    logic       eng_done_i;
    logic [7:0] eng_avg_i;
    logic [7:0] avg_o;
    logic       avg_valid_o;
    logic       warm_o;
    logic       clr_err_i;
    logic       err_overrun_o;
    logic       err_timeout_o;

    int checks;
    int errors;
    int cyc;
    int eng_delay;
    bit eng_never;
    int eng_cnt;

    moving_average_if #(.DATA_W(8)) src_if ();

    moving_average_ctrl #(
        .DATA_W       (8),
        .FILTER_POWER (2),
        .DIV_W        (8),
        .TIMEOUT      (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .src           (src_if.slave),
        .div_i         (div_i),
        .eng_data_o    (eng_data_o),
        .eng_strobe_o  (eng_strobe_o),
        .eng_done_i    (eng_done_i),
        .eng_avg_i     (eng_avg_i),
        .avg_o         (avg_o),
        .avg_valid_o   (avg_valid_o),
        .warm_o        (warm_o),
        .clr_err_i     (clr_err_i),
        .err_overrun_o (err_overrun_o),
        .err_timeout_o (err_timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: done pulses eng_delay cycles after the strobe cycle.
    initial eng_cnt = 0;
    always @(negedge clk) begin
        eng_done_i = 1'b0;
        if (!rst_n) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) eng_done_i = 1'b1;
            end
            if (eng_strobe_o && !eng_never) eng_cnt = eng_delay;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ena = 1'b0;
        clr_err_i = 1'b0;
        eng_never = 1'b0;
        src_if.src_valid_i = 1'b0;
        src_if.src_data_i = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
    endtask

    // Handshake one sample; returns in the cycle after accept (T+1).
    task automatic send(input logic [7:0] d, output int t);
        bit ok;
        ok = 1'b0;
        src_if.src_data_i = d;
        src_if.src_valid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (src_if.src_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        t = cyc;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: ready=%0b want 1 within 64 cycles",
                     src_if.src_ready_o);
        end
        @(negedge clk);
        src_if.src_valid_i = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] d);
        int t;
        send(d, t);
        repeat (eng_delay + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [29:0] got;
        div_i = 8'd0;
        rst_n = 1'b0;
        ena = 1'b0;
        clr_err_i = 1'b0;
        eng_delay = 6;
        eng_never = 1'b0;
        eng_avg_i = 8'h00;
        src_if.src_valid_i = 1'b0;
        src_if.src_data_i = 8'h00;
        repeat (2) @(negedge clk);
        got = {src_if.src_ready_o, eng_data_o, eng_strobe_o, avg_o,
               avg_valid_o, warm_o, err_overrun_o, err_timeout_o};
        checks++;
        if (got !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        rst_n = 1'b1;
        src_if.src_valid_i = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (src_if.src_ready_o !== 1'b0 || eng_strobe_o !== 1'b0) begin
            errors++;
            $display("FAIL ena_low_block: ready=%0b strobe=%0b want 0 0",
                     src_if.src_ready_o, eng_strobe_o);
        end
        src_if.src_valid_i = 1'b0;
    endtask

    task automatic test_single();
        int t;
        div_i = 8'd0;
        do_reset();
        eng_delay = 6;
        eng_avg_i = 8'h3C;
        send(8'h10, t);
        checks++;
        if (eng_strobe_o !== 1'b1 || eng_data_o !== 8'h10) begin
            errors++;
            $display("FAIL single_strobe: strobe=%0b data=%h want 1 10",
                     eng_strobe_o, eng_data_o);
        end
        @(negedge clk);
        checks++;
        if (eng_strobe_o !== 1'b0) begin
            errors++;
            $display("FAIL single_strobe_once: strobe=%0b want 0", eng_strobe_o);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (avg_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: valid=%0b want 0", avg_valid_o);
        end
        @(negedge clk);
        checks++;
        if (avg_valid_o !== 1'b1 || avg_o !== 8'h3C) begin
            errors++;
            $display("FAIL single_capture: valid=%0b avg=%h want 1 3c",
                     avg_valid_o, avg_o);
        end
        @(negedge clk);
        checks++;
        if (avg_valid_o !== 1'b0 || avg_o !== 8'h3C || err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL single_after: valid=%0b avg=%h to=%0b want 0 3c 0",
                     avg_valid_o, avg_o, err_timeout_o);
        end
    endtask

    task automatic test_rate_warm();
        int acc[5];
        int n_acc;
        int n_avg;
        bit adv;
        n_acc = 0;
        n_avg = 0;
        adv = 1'b0;
        div_i = 8'd3;
        do_reset();
        eng_delay = 1;
        eng_avg_i = 8'h21;
        src_if.src_data_i = 8'd1;
        src_if.src_valid_i = 1'b1;
        for (int i = 0; i < 100 && n_avg < 5; i++) begin
            if (adv) begin
                adv = 1'b0;
                if (n_acc < 5) src_if.src_data_i = 8'(n_acc + 1);
                else src_if.src_valid_i = 1'b0;
            end
            if (eng_strobe_o && n_acc > 0) begin
                checks++;
                if (eng_data_o !== 8'(n_acc)) begin
                    errors++;
                    $display("FAIL rate_data: got %h want %h",
                             eng_data_o, 8'(n_acc));
                end
            end
            if (avg_valid_o) begin
                n_avg++;
                checks++;
                if (warm_o !== (n_avg >= 4)) begin
                    errors++;
                    $display("FAIL rate_warm: result %0d warm=%0b want %0b",
                             n_avg, warm_o, (n_avg >= 4));
                end
            end
            if (src_if.src_valid_i && src_if.src_ready_o && n_acc < 5) begin
                acc[n_acc] = cyc;
                n_acc++;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        src_if.src_valid_i = 1'b0;
        checks++;
        if (n_acc != 5 || n_avg != 5) begin
            errors++;
            $display("FAIL rate_count: accepts=%0d results=%0d want 5 5",
                     n_acc, n_avg);
        end else begin
            for (int k = 1; k < 5; k++) begin
                checks++;
                if (acc[k] - acc[k-1] != 4) begin
                    errors++;
                    $display("FAIL rate_spacing: gap %0d got %0d want 4",
                             k, acc[k] - acc[k-1]);
                end
            end
        end
        repeat (6) @(negedge clk);
        checks++;
        if (warm_o !== 1'b1) begin
            errors++;
            $display("FAIL rate_warm_hold: warm=%0b want 1", warm_o);
        end
    endtask

    task automatic test_timeout();
        int t;
        div_i = 8'd0;
        do_reset();
        eng_never = 1'b1;
        send(8'h55, t);
        repeat (16) @(negedge clk);
        checks++;
        if (err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: to=%0b want 0", err_timeout_o);
        end
        @(negedge clk);
        checks++;
        if (err_timeout_o !== 1'b1 || src_if.src_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: to=%0b ready=%0b want 1 1",
                     err_timeout_o, src_if.src_ready_o);
        end
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        checks++;
        if (err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: to=%0b want 0", err_timeout_o);
        end
        eng_never = 1'b0;
    endtask

    task automatic test_overrun();
        int t;
        div_i = 8'd0;
        do_reset();
        eng_delay = 10;
        eng_avg_i = 8'h44;
        send(8'h33, t);
        repeat (2) @(negedge clk);
        checks++;
        if (err_overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: ovr=%0b want 1", err_overrun_o);
        end
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        checks++;
        if (err_overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_wins: ovr=%0b want 1", err_overrun_o);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (avg_valid_o !== 1'b1 || avg_o !== 8'h44 || err_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_capture: valid=%0b avg=%h to=%0b want 1 44 0",
                     avg_valid_o, avg_o, err_timeout_o);
        end
        clr_err_i = 1'b1;
        @(negedge clk);
        clr_err_i = 1'b0;
        checks++;
        if (err_overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%0b want 0", err_overrun_o);
        end
    endtask

    task automatic test_hold();
        int t;
        div_i = 8'd0;
        do_reset();
        eng_delay = 4;
        send(8'hA5, t);
        src_if.src_data_i = 8'hFF;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (eng_data_o !== 8'hA5) begin
                errors++;
                $display("FAIL hold_data: cycle +%0d got %h want a5",
                         k + 1, eng_data_o);
            end
            @(negedge clk);
        end
        send(8'hFF, t);
        checks++;
        if (eng_data_o !== 8'hFF) begin
            errors++;
            $display("FAIL hold_update: got %h want ff", eng_data_o);
        end
        repeat (eng_delay + 2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t;
        int seen;
        logic [29:0] got;
        div_i = 8'd0;
        do_reset();
        eng_delay = 1;
        eng_avg_i = 8'h77;
        run_txn(8'h01);
        eng_never = 1'b1;
        send(8'h02, t);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        got = {src_if.src_ready_o, eng_data_o, eng_strobe_o, avg_o,
               avg_valid_o, warm_o, err_overrun_o, err_timeout_o};
        checks++;
        if (got !== 30'd0) begin
            errors++;
            $display("FAIL reset_async: got %h want 0", got);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        eng_never = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (eng_strobe_o) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_strobe: strobes=%0d want 0", seen);
        end
        run_txn(8'h03);
        run_txn(8'h04);
        run_txn(8'h05);
        checks++;
        if (warm_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_warm_cleared: warm=%0b want 0", warm_o);
        end
        run_txn(8'h06);
        checks++;
        if (warm_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_warm_refill: warm=%0b want 1", warm_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_rate_warm();
        test_timeout();
        test_overrun();
        test_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/moving_average_ctrl.md
# moving_average_ctrl

Sequencing controller for the moving-average filter engine. It takes samples from an upstream source over a valid/ready handshake and paces them with a programmable sample-rate divider. It presents each accepted sample to the engine as a held data word plus a one-cycle strobe, waits for the engine's done strobe under a watchdog, and captures the result. It reports warm-up status (window filled) and sticky overrun/timeout errors. It sits between the tile I/O pins and the filter engine.

## Interface
Parameters:
- DATA_W, 8, sample and result width
- FILTER_POWER, 2, log2 of engine window; window = 1<<FILTER_POWER
- DIV_W, 8, width of rate divider
- TIMEOUT, 16, max cycles in BUSY waiting for engine done (must be ≥ window+2)

Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, reset, asynchronous, active-low
- ena, in, 1, enable; low freezes divider and blocks new accepts
- src_data_i, in, DATA_W, sample from source
- src_valid_i, in, 1, sample valid
- src_ready_o, out, 1, controller accepts sample this cycle
- div_i, in, DIV_W, one sample slot every div_i+1 cycles (0 = every cycle)
- eng_data_o, out, DATA_W, held sample driven to engine data input
- eng_strobe_o, out, 1, one-cycle start pulse to engine
- eng_done_i, in, 1, engine done strobe (engine in AVERAGE state)
- eng_avg_i, in, DATA_W, engine average output, valid the cycle after done
- avg_o, out, DATA_W, last captured average
- avg_valid_o, out, 1, one-cycle pulse when avg_o updates
- warm_o, out, 1, high once window results have been captured since reset
- clr_err_i, in, 1, clears sticky error flags
- err_overrun_o, out, 1, sticky: slot tick while a transaction was in flight
- err_timeout_o, out, 1, sticky: engine done not seen within TIMEOUT

## Operation
- Divider: counter counts 0..div_i while ena=1 and emits tick when count==div_i, then wraps to 0. If div_i is changed below the current count, the counter wraps to 0 next cycle with no tick.
- slot_pend flag: set on tick, cleared on accept.
- FSM states: IDLE, ISSUE, BUSY, CAPTURE.
  - IDLE: src_ready_o = ena & slot_pend. On src_valid_i & src_ready_o, latch src_data_i into hold register and go to ISSUE.
  - ISSUE: eng_strobe_o=1 for exactly this cycle, then go to BUSY.
  - BUSY: watchdog counts from 0. If eng_done_i=1, go to CAPTURE. Else, at count TIMEOUT-1, set err_timeout_o and go to IDLE. If done and timeout occur in the same cycle, done wins.
  - CAPTURE: register eng_avg_i into avg_o, pulse avg_valid_o, increment warm counter (saturates at window), then go to IDLE.
- eng_data_o equals the hold register at all times. It changes only on accept, so it is stable from strobe through done and the engine's shift.
- Overrun: a tick while state≠IDLE sets err_overrun_o. slot_pend stays set, so at most one slot is pending.
- Starvation: ticks with no src_valid_i in IDLE are not errors.
- clr_err_i clears both sticky flags. If a new error event occurs in the same cycle, set wins.
- ena=0: divider holds, src_ready_o=0, and an in-flight transaction completes normally back to IDLE.
- Unknown state encoding returns to IDLE.

## Timing
- Reset values: src_ready_o=0, eng_data_o=0, eng_strobe_o=0, avg_o=0, avg_valid_o=0, warm_o=0, err_overrun_o=0, err_timeout_o=0. State=IDLE, divider=0, slot_pend=0.
- Accept in cycle T gives eng_strobe_o=1 in T+1.
- eng_done_i in cycle D gives CAPTURE in D+1 and avg_o/avg_valid_o visible in D+2.
- Minimum spacing between accepts: (D−T)+2 cycles.
- warm_o rises in the same cycle as the window-th avg_valid_o.
- All outputs are registered except src_ready_o, which is a combinational AND of ena, slot_pend and state==IDLE.
- Reset asserted mid-transaction aborts immediately. No strobe is issued after rst_n deasserts until a new accept.

## Structure
- Package moving_average_pkg holds the FSM state typedef (2-bit encoding), DATA_W, FILTER_POWER and the window-size localparam, shared with the filter engine.
- One sub-module, ma_tick_gen: the rate divider plus slot_pend flag, with inputs ena, div_i, clr_pend and output pend.
- The FSM, watchdog, warm counter and error flags stay in the top.

## Test plan
- div_i=0, engine model asserts done 6 cycles after strobe and drives eng_avg_i=0x3C: send 0x10. Expect strobe at T+1, avg_o=0x3C and avg_valid_o pulse at strobe+8, and no errors.
- div_i=3, src_valid_i held high with data 1,2,3,4,5: expect accepts spaced by max(4, engine turnaround). warm_o rises on the 4th avg_valid_o (window=4) and stays high.
- Engine model never asserts done, TIMEOUT=16: expect err_timeout_o=1 exactly 16 cycles after entering BUSY, then a return to IDLE with src_ready_o=1 on the next slot. Then clr_err_i pulse: expect err_timeout_o=0.
- div_i=0 with done delayed 10 cycles: expect err_overrun_o=1 during BUSY. Assert clr_err_i in a cycle where a tick also occurs in BUSY: err_overrun_o stays 1.
- Hold data stability: after accept of 0xA5, drive src_data_i=0xFF. Expect eng_data_o=0xA5 through done+1.
- rst_n pulled low while in BUSY: expect all outputs 0 immediately (asynchronous), no eng_strobe_o after release until a new handshake, and warm counter back to 0.
